// File: rtl/rv32v_hazard_pkg.sv
// Shared types and constants for the vector-pipeline hazard controller.
//   hazard_state_t : IDLE / DRAIN states of the fetch-drain FSM
//   *_DEF          : default parameter values
//   drain_cnt_w()  : width of the drain down-counter for a given drain length
package rv32v_hazard_pkg;

    localparam int unsigned NUM_STAGES_DEF   = 5;
    localparam int unsigned CSR_STAGE_DEF    = 4;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned CNT_W_DEF        = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } hazard_state_t;

    // Counter must hold DRAIN_CYCLES itself; never narrower than one bit.
    function automatic int unsigned drain_cnt_w(input int unsigned drain_cycles);
        int unsigned w;
        w = $clog2(drain_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rv32v_hazard_ctrl_if.sv
// Hazard-control bundle between the vector pipeline and the hazard controller.
//   busy         : per-stage "cannot advance" flags (pipeline -> ctrl)
//   csr_update   : CSR-writing instruction committing in the CSR stage
//   ext_flush    : full-pipeline kill from the scalar core
//   stall/flush  : per-stage hold / bubble controls (ctrl -> pipeline)
//   drain_active : fetch drain in progress
//   stall_cycles : saturating count of cycles stage 0 was stalled
// master = pipeline side, slave = controller side.
interface rv32v_hazard_ctrl_if #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned CNT_W      = 16
);
    logic [NUM_STAGES-1:0] busy;
    logic                  csr_update;
    logic                  ext_flush;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic                  drain_active;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output busy, csr_update, ext_flush,
        input  stall, flush, drain_active, stall_cycles
    );

    modport slave (
        input  busy, csr_update, ext_flush,
        output stall, flush, drain_active, stall_cycles
    );
endinterface

// File: rtl/rv32v_stall_chain.sv
// Pure combinational backpressure chain.
//   busy      : per-stage busy flags, index 0 youngest
//   raw_stall : stage i stalls when it or any older stage is busy
//   bubble    : stage i+1 gets a bubble when stage i holds but i+1 moves on
module rv32v_stall_chain #(
    parameter int unsigned NUM_STAGES = 5
) (
    input  logic [NUM_STAGES-1:0] busy,
    output logic [NUM_STAGES-1:0] raw_stall,
    output logic [NUM_STAGES-1:0] bubble
);

    // Suffix OR, written per bit so no bit depends on another bit of the same vector.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_raw
        assign raw_stall[g] = |busy[NUM_STAGES-1:g];
    end

    assign bubble[0] = 1'b0;
    for (genvar g = 0; g < NUM_STAGES - 1; g++) begin : g_bubble
        assign bubble[g+1] = raw_stall[g] & ~raw_stall[g+1];
    end

endmodule

// File: rtl/rv32v_hazard_ctrl.sv
// Stall/flush controller for the vector pipeline.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : slave side of rv32v_hazard_ctrl_if
//              (busy/csr_update/ext_flush in; stall/flush combinational out;
//               drain_active/stall_cycles registered out)
// A committed CSR write flushes the younger stages and holds stage 0 for
// DRAIN_CYCLES cycles so fetch restarts with the new CSR state.
module rv32v_hazard_ctrl
    import rv32v_hazard_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = NUM_STAGES_DEF,
    parameter int unsigned CSR_STAGE    = CSR_STAGE_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    rv32v_hazard_ctrl_if.slave bus
);

    localparam int unsigned DCW = drain_cnt_w(DRAIN_CYCLES);

    logic [NUM_STAGES-1:0] raw_stall;
    logic [NUM_STAGES-1:0] bubble;
    logic [NUM_STAGES-1:0] csr_mask;
    logic [NUM_STAGES-1:0] flush_c;
    logic [NUM_STAGES-1:0] stall_c;
    logic                  csr_fire_c;

    hazard_state_t         state_q, state_d;
    logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic                  drain_active_q;

    rv32v_stall_chain #(
        .NUM_STAGES (NUM_STAGES)
    ) u_stall_chain (
        .busy      (bus.busy),
        .raw_stall (raw_stall),
        .bubble    (bubble)
    );

    // Stages younger than the CSR stage are squashed on a CSR commit.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_csr_mask
        assign csr_mask[g] = (g < CSR_STAGE);
    end

    // A stalled CSR stage keeps csr_update high; it only commits once it moves.
    assign csr_fire_c = bus.csr_update & ~raw_stall[CSR_STAGE] & ~bus.ext_flush;

    assign drain_active_q = (state_q == DRAIN);

    // Flush and stall; reset forces all bubbles and no holds. Flush beats stall.
    always_comb begin
        flush_c = '0;
        stall_c = '0;
        if (RST) begin
            flush_c = '1;
        end else begin
            flush_c = {NUM_STAGES{bus.ext_flush}} | bubble
                    | (csr_fire_c ? csr_mask : '0);
            stall_c = (raw_stall | NUM_STAGES'(drain_active_q)) & ~flush_c;
        end
    end

    // Drain FSM next-state and saturating stall counter.
    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        stall_cycles_d = stall_cycles_q;

        unique case (state_q)
            IDLE: begin
                if (bus.ext_flush) begin
                    drain_cnt_d = '0;
                end else if (csr_fire_c && (DRAIN_CYCLES > 0)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DCW'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                if (bus.ext_flush) begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                end else if (csr_fire_c) begin
                    drain_cnt_d = DCW'(DRAIN_CYCLES);
                end else if (drain_cnt_q == DCW'(1)) begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                drain_cnt_d = '0;
            end
        endcase

        if (stall_c[0] && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            drain_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall_c;
    assign bus.flush        = flush_c;
    assign bus.drain_active = drain_active_q;
    assign bus.stall_cycles = stall_cycles_q;

endmodule
